// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the frame-memory write path.
package vga_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;
    localparam int COLOR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;
endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip of a requested rectangle against the visible screen.
// Produces the inclusive bottom-right corner, an empty flag and the first
// pixel address. Outputs are only meaningful when empty is low.
module fb_rect_clip #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H,
    parameter int ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [9:0]        w,
    input  logic [8:0]        h,
    output logic [9:0]        x1,
    output logic [8:0]        y1,
    output logic              empty,
    output logic [ADDR_W-1:0] start_addr
);
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - 1);
    localparam logic [10:0] Y_MAX = 11'(SCREEN_H - 1);

    logic [10:0] x_end;
    logic [10:0] y_end;

    // 11-bit corner sums cannot overflow for 10/9-bit inputs; a zero
    // width or height wraps here but is caught by the empty flag.
    always_comb begin
        x_end      = {1'b0, x} + {1'b0, w} - 11'd1;
        y_end      = {2'b0, y} + {2'b0, h} - 11'd1;
        x1         = (x_end > X_MAX) ? X_MAX[9:0] : x_end[9:0];
        y1         = (y_end > Y_MAX) ? Y_MAX[8:0] : y_end[8:0];
        empty      = (w == 10'd0) || (h == 9'd0) ||
                     ({1'b0, x} >= 11'(SCREEN_W)) ||
                     ({2'b0, y} >= 11'(SCREEN_H));
        start_addr = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    end
endmodule

// File: rtl/fb_rect_writer.sv
// Filled-rectangle writer for the palette-index frame memory.
// Accepts one request at a time, clips it in a single cycle, then streams
// one pixel write per permitted cycle in raster order. Row stepping is an
// add of a precomputed stride so only the clip cycle needs a multiply.
module fb_rect_writer #(
    parameter int SCREEN_W       = vga_pkg::SCREEN_W,
    parameter int SCREEN_H       = vga_pkg::SCREEN_H,
    parameter int ADDR_W         = vga_pkg::ADDR_W,
    parameter bit SYNC_TO_VBLANK = 1'b1
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iVBLANK,
    input  logic              iREQ_VALID,
    output logic              oREQ_READY,
    input  logic [9:0]        iREQ_X,
    input  logic [8:0]        iREQ_Y,
    input  logic [9:0]        iREQ_W,
    input  logic [8:0]        iREQ_H,
    input  logic [7:0]        iREQ_COLOR,
    output logic              oWE,
    output logic [ADDR_W-1:0] oWADDR,
    output logic [7:0]        oWDATA,
    output logic              oBUSY,
    output logic              oDONE
);
    import vga_pkg::*;

    fsm_state_e         state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [8:0]         y_q, y_d;
    logic [9:0]         w_q, w_d;
    logic [8:0]         h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [9:0]         x1_q, x1_d;
    logic [8:0]         y1_q, y1_d;
    logic [9:0]         col_q, col_d;
    logic [8:0]         row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [9:0]         clip_x1;
    logic [8:0]         clip_y1;
    logic               clip_empty;
    logic [ADDR_W-1:0]  clip_start;
    logic               permit;
    logic [ADDR_W-1:0]  row_stride;

    fb_rect_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .ADDR_W   (ADDR_W)
    ) u_clip (
        .x          (x_q),
        .y          (y_q),
        .w          (w_q),
        .h          (h_q),
        .x1         (clip_x1),
        .y1         (clip_y1),
        .empty      (clip_empty),
        .start_addr (clip_start)
    );

    // Write gating and the jump from the last pixel of a row to the first
    // pixel of the next one.
    always_comb begin
        permit     = (SYNC_TO_VBLANK == 1'b0) || iVBLANK;
        row_stride = ADDR_W'(SCREEN_W) - ADDR_W'(x1_q - x_q);
    end

    // Next-state and counter update; counters freeze while writes are gated.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (iREQ_VALID) begin
                    x_d     = iREQ_X;
                    y_d     = iREQ_Y;
                    w_d     = iREQ_W;
                    h_d     = iREQ_H;
                    color_d = iREQ_COLOR;
                    state_d = ST_CLIP;
                end
            end
            ST_CLIP: begin
                x1_d  = clip_x1;
                y1_d  = clip_y1;
                col_d = x_q;
                row_d = y_q;
                if (clip_empty) begin
                    // Leave the address alone: the unclipped start may be
                    // off-screen.
                    state_d = ST_DONE;
                end else begin
                    addr_d  = clip_start;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (permit) begin
                    if (col_q == x1_q) begin
                        if (row_q == y1_q) begin
                            state_d = ST_DONE;
                        end else begin
                            col_d  = x_q;
                            row_d  = row_q + 9'd1;
                            addr_d = addr_q + row_stride;
                        end
                    end else begin
                        col_d  = col_q + 10'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any rectangle in flight.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs decode straight from flops; write enable also follows the
    // vblank level so a gated cycle never reaches memory.
    always_comb begin
        oREQ_READY = (state_q == ST_IDLE);
        oBUSY      = (state_q != ST_IDLE);
        oDONE      = (state_q == ST_DONE);
        oWE        = (state_q == ST_FILL) && permit;
        oWADDR     = addr_q;
        oWDATA     = color_q;
    end
endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: table of rectangles plus hand-written
// back-to-back and mid-fill reset sequences.
module tb_fb_rect_writer;
    logic        clk;
    logic        rst_n;
    logic        vblank;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_x;
    logic [8:0]  req_y;
    logic [9:0]  req_w;
    logic [8:0]  req_h;
    logic [7:0]  req_color;
    logic        we;
    logic [18:0] waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    fb_rect_writer #(.SYNC_TO_VBLANK(1'b1)) dut (
        .iVGA_CLK   (clk),
        .iRST_n     (rst_n),
        .iVBLANK    (vblank),
        .iREQ_VALID (req_valid),
        .oREQ_READY (req_ready),
        .iREQ_X     (req_x),
        .iREQ_Y     (req_y),
        .iREQ_W     (req_w),
        .iREQ_H     (req_h),
        .iREQ_COLOR (req_color),
        .oWE        (we),
        .oWADDR     (waddr),
        .oWDATA     (wdata),
        .oBUSY      (busy),
        .oDONE      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic [9:0] w;
        logic [8:0] h;
        logic [7:0] c;
        int         n;       // expected write count
        int         first;   // expected first address
        int         last;    // expected last address
        int         gate;    // drop vblank after this many writes (0 = never)
        int         resume;  // expected address of first write after gating
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [9:0] x, input logic [8:0] y,
                          input logic [9:0] w, input logic [8:0] h,
                          input logic [7:0] c);
        @(posedge clk); #1;
        req_x = x; req_y = y; req_w = w; req_h = h; req_color = c;
        req_valid = 1'b1;
        @(negedge clk);
        chk("ready_before_req", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, nw, first_a, last_a, first_cyc, last_cyc, done_cyc;
        int bad_d, oob, hold, held_bad, resume_a, busy_n1;
        bit after_gate;
        cyc = 0; nw = 0; first_a = -1; last_a = -1; first_cyc = -1;
        last_cyc = -1; done_cyc = -1; bad_d = 0; oob = 0; hold = 0;
        held_bad = 0; resume_a = -1; busy_n1 = 0; after_gate = 0;
        launch(v.x, v.y, v.w, v.h, v.c);
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy_n1 = int'(busy && !req_ready);
            if (hold > 0 && (we || waddr !== 19'(v.resume))) held_bad++;
            if (we) begin
                if (nw == 0) begin first_a = int'(waddr); first_cyc = cyc; end
                if (after_gate && hold == 0 && resume_a < 0) resume_a = int'(waddr);
                nw++;
                last_a = int'(waddr);
                last_cyc = cyc;
                if (wdata !== v.c) bad_d++;
                if (waddr >= 19'd307200) oob++;
            end
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
            if (v.gate > 0 && nw == v.gate && !after_gate) begin
                after_gate = 1;
                hold = 100;
                vblank = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) vblank = 1'b1;
            end
        end
        vblank = 1'b1;
        $display("[TB] vec %0d: %0d writes, done at N+%0d", idx, nw, done_cyc);
        chk($sformatf("v%0d_timeout", idx), int'(done_cyc >= 0), 1);
        chk($sformatf("v%0d_busy_n1", idx), busy_n1, 1);
        chk($sformatf("v%0d_count", idx), nw, v.n);
        chk($sformatf("v%0d_bad_data", idx), bad_d, 0);
        chk($sformatf("v%0d_oob", idx), oob, 0);
        if (v.n > 0) begin
            chk($sformatf("v%0d_first_addr", idx), first_a, v.first);
            chk($sformatf("v%0d_last_addr", idx), last_a, v.last);
            chk($sformatf("v%0d_first_cyc", idx), first_cyc, 2);
            chk($sformatf("v%0d_done_cyc", idx), done_cyc, last_cyc + 1);
        end else begin
            chk($sformatf("v%0d_done_cyc", idx), done_cyc, 2);
        end
        if (v.gate > 0) begin
            chk($sformatf("v%0d_gated_hold", idx), held_bad, 0);
            chk($sformatf("v%0d_resume_addr", idx), resume_a, v.resume);
        end
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", idx), int'(req_ready), 1);
        chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
        chk($sformatf("v%0d_done_pulse", idx), int'(done), 0);
    endtask

    vec_t vecs[9];

    initial begin
        int cyc, na, nb, bad_a, bad_b, first_b, first_b_cyc, last_a, last_b;
        int done_a, ready_rise, phase, nw, stray;
        tests = 0; fails = 0;
        rst_n = 1'b0; vblank = 1'b1; req_valid = 1'b0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0;

        //          x    y    w   h   color  n   first   last    gate resume
        vecs[0] = '{10'd5,   9'd2,   10'd10, 9'd4,  8'h3C, 40, 1285,   3214,   0, 0};
        vecs[1] = '{10'd630, 9'd475, 10'd20, 9'd10, 8'h5A, 50, 304630, 307199, 0, 0};
        vecs[2] = '{10'd5,   9'd2,   10'd0,  9'd4,  8'h01, 0,  0,      0,      0, 0};
        vecs[3] = '{10'd700, 9'd2,   10'd10, 9'd4,  8'h02, 0,  0,      0,      0, 0};
        vecs[4] = '{10'd5,   9'd2,   10'd10, 9'd4,  8'h3C, 40, 1285,   3214,   7, 1292};
        vecs[5] = '{10'd0,   9'd0,   10'd1,  9'd1,  8'hFF, 1,  0,      0,      0, 0};
        vecs[6] = '{10'd10,  9'd479, 10'd4,  9'd9,  8'h77, 4,  306570, 306573, 0, 0};
        vecs[7] = '{10'd639, 9'd0,   10'd5,  9'd2,  8'h81, 2,  639,    1279,   0, 0};
        vecs[8] = '{10'd0,   9'd480, 10'd5,  9'd5,  8'h03, 0,  0,      0,      0, 0};

        // Reset state
        #12;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_we",    int'(we), 0);
        chk("rst_addr",  int'(waddr), 0);
        chk("rst_data",  int'(wdata), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Back-to-back: valid stays high, second request must wait for ready.
        @(posedge clk); #1;
        req_x = 10'd0; req_y = 9'd0; req_w = 10'd3; req_h = 9'd2; req_color = 8'h11;
        req_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready_a", int'(req_ready), 1);
        @(posedge clk); #1;
        req_x = 10'd10; req_y = 9'd10; req_w = 10'd2; req_h = 9'd2; req_color = 8'h22;
        cyc = 0; na = 0; nb = 0; bad_a = 0; bad_b = 0; first_b = -1;
        first_b_cyc = -1; last_a = -1; last_b = -1; done_a = -1;
        ready_rise = 0; phase = 0;
        while (phase < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (we) begin
                if (phase == 0) begin
                    na++; last_a = int'(waddr);
                    if (wdata !== 8'h11) bad_a++;
                end else begin
                    if (nb == 0) begin first_b = int'(waddr); first_b_cyc = cyc; end
                    nb++; last_b = int'(waddr);
                    if (wdata !== 8'h22) bad_b++;
                end
            end
            if (phase == 1 && cyc == done_a + 1) ready_rise = int'(req_ready);
            if (done) begin
                if (phase == 0) done_a = cyc;
                phase++;
            end
            @(posedge clk); #1;
            if (phase == 1 && cyc == done_a + 1) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("b2b_timeout",     int'(phase == 2), 1);
        chk("b2b_count_a",     na, 6);
        chk("b2b_last_a",      last_a, 642);
        chk("b2b_data_a",      bad_a, 0);
        chk("b2b_ready_rise",  ready_rise, 1);
        chk("b2b_count_b",     nb, 4);
        chk("b2b_first_b",     first_b, 6410);
        chk("b2b_last_b",      last_b, 7051);
        chk("b2b_first_b_cyc", first_b_cyc, done_a + 3);
        chk("b2b_data_b",      bad_b, 0);
        @(negedge clk);
        chk("b2b_idle", int'(req_ready && !busy), 1);

        // Reset in the middle of a fill.
        launch(10'd5, 9'd2, 10'd10, 9'd4, 8'h3C);
        nw = 0; cyc = 0;
        while (nw < 12 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (we) nw++;
        end
        chk("rst_mid_reach12", nw, 12);
        @(posedge clk); #2;
        chk("rst_mid_we_before", int'(we), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_now",  int'(we), 0);
        chk("rst_mid_ready",   int'(req_ready), 1);
        chk("rst_mid_busy",    int'(busy), 0);
        chk("rst_mid_addr",    int'(waddr), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (we || busy || !req_ready || done) stray++;
        end
        chk("rst_mid_residual", stray, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
